// File: rtl/shift_unit_seq.sv
// Multi-cycle barrel shifter for the ALU shift path: one log2 stage per clock, highest stage first.
// Optional build macro SHIFT_FAST_ZERO_EN: amount==0 bypasses the stage sequence.
module shift_unit_seq #(
    parameter int WIDTH = 16,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             dir,
    input  logic             arith,
    input  logic             rotate,
    input  logic [AMT_W-1:0] amount,
    input  logic [WIDTH-1:0] in_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out_data,
    output logic             carry_out,
    output logic             zero,
    output logic             negative
);

    typedef enum logic [1:0] {IDLE, STAGE, ZERO, DONE} state_t;

    state_t           r_state;
    logic [AMT_W-1:0] r_idx;
    logic [WIDTH-1:0] r_val;
    logic [AMT_W-1:0] r_amt;
    logic             r_dir;
    logic             r_arith;
    logic             r_rot;
    logic             r_sign;
    logic             r_cy;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_out;
    logic             r_cy_out;
    logic             r_zero;
    logic             r_neg;

    int               w_s;
    logic             w_active;
    logic [WIDTH-1:0] w_val_nxt;
    logic             w_cy_nxt;

    function automatic logic [WIDTH-1:0] shift_stage(input logic [WIDTH-1:0] v, input int s,
                                                     input logic d, input logic ar,
                                                     input logic ro, input logic sg);
        logic [WIDTH-1:0] ones;
        logic [WIDTH-1:0] res;
        ones = '1;
        if (!d)
            res = ro ? ((v << s) | (v >> (WIDTH - s))) : (v << s);
        else if (ro)
            res = (v >> s) | (v << (WIDTH - s));
        else if (ar && sg)
            res = (v >> s) | ~(ones >> s);
        else
            res = v >> s;
        return res;
    endfunction

    // Bit that crosses the word boundary in this stage: the one at the far edge of the moved group.
    function automatic logic stage_carry(input logic [WIDTH-1:0] v, input int s, input logic d);
        logic [WIDTH-1:0] t;
        t = d ? (v >> (s - 1)) : (v >> (WIDTH - s));
        return t[0];
    endfunction

    assign w_s       = 1 << r_idx;
    assign w_active  = |(r_amt & (AMT_W'(1) << r_idx));
    assign w_val_nxt = w_active ? shift_stage(r_val, w_s, r_dir, r_arith, r_rot, r_sign) : r_val;
    assign w_cy_nxt  = w_active ? stage_carry(r_val, w_s, r_dir) : r_cy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_out    <= '0;
            r_cy_out <= 1'b0;
            r_zero   <= 1'b1;
            r_neg    <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_val   <= in_data;
                        r_amt   <= amount;
                        r_dir   <= dir;
                        r_arith <= arith;
                        r_rot   <= rotate;
                        r_sign  <= in_data[WIDTH-1];
                        r_cy    <= 1'b0;
                        r_idx   <= AMT_W'(AMT_W - 1);
`ifdef SHIFT_FAST_ZERO_EN
                        if (amount == '0) begin
                            r_state <= ZERO;
                        end else begin
                            r_state <= STAGE;
                            r_busy  <= 1'b1;
                        end
`else
                        r_state <= STAGE;
                        r_busy  <= 1'b1;
`endif
                    end else begin
                        r_state <= IDLE;
                    end
                end
                STAGE: begin
                    r_val <= w_val_nxt;
                    r_cy  <= w_cy_nxt;
                    if (r_idx == '0) begin
                        r_state  <= DONE;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_out    <= w_val_nxt;
                        r_cy_out <= w_cy_nxt;
                        r_zero   <= (w_val_nxt == '0);
                        r_neg    <= w_val_nxt[WIDTH-1];
                    end else begin
                        r_idx <= r_idx - 1'b1;
                    end
                end
                ZERO: begin
                    r_state  <= DONE;
                    r_done   <= 1'b1;
                    r_out    <= r_val;
                    r_cy_out <= 1'b0;
                    r_zero   <= (r_val == '0);
                    r_neg    <= r_val[WIDTH-1];
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign out_data  = r_out;
    assign carry_out = r_cy_out;
    assign zero      = r_zero;
    assign negative  = r_neg;

endmodule

// File: tb/tb_shift_unit_seq.sv
// Directed bench for shift_unit_seq: vector table plus handshake/reset corner sequences.
module tb_shift_unit_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic        dir;
    logic        arith;
    logic        rotate;
    logic [3:0]  amount;
    logic [15:0] in_data;
    logic        busy;
    logic        done;
    logic [15:0] out_data;
    logic        carry_out;
    logic        zero;
    logic        negative;

    int checks;
    int failures;

    typedef struct {
        logic        d;
        logic        a;
        logic        r;
        logic [3:0]  amt;
        logic [15:0] din;
        logic [15:0] exp_out;
        logic        exp_cy;
    } vec_t;

    vec_t vecs[13];

    shift_unit_seq #(.WIDTH(16), .AMT_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .dir(dir), .arith(arith), .rotate(rotate),
        .amount(amount), .in_data(in_data), .busy(busy), .done(done), .out_data(out_data),
        .carry_out(carry_out), .zero(zero), .negative(negative)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int exp_lat(input logic [3:0] amt);
`ifdef SHIFT_FAST_ZERO_EN
        return (amt == 4'd0) ? 1 : 4;
`else
        return (amt == 4'd0) ? 4 : 4;
`endif
    endfunction

    function automatic logic exp_busy(input logic [3:0] amt);
`ifdef SHIFT_FAST_ZERO_EN
        return amt != 4'd0;
`else
        return (amt == 4'd0) ? 1'b1 : 1'b1;
`endif
    endfunction

    // Presents an operation and returns #1 after the accepting edge.
    task automatic start_op(input logic d, input logic a, input logic r,
                            input logic [3:0] amt, input logic [15:0] din);
        @(negedge clk);
        dir = d; arith = a; rotate = r; amount = amt; in_data = din; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic chk_result(input string name, input logic [15:0] eo, input logic ec);
        chk({name, "_out"}, 32'(out_data), 32'(eo));
        chk({name, "_carry"}, 32'(carry_out), 32'(ec));
        chk({name, "_zero"}, 32'(zero), 32'(eo == 16'h0));
        chk({name, "_neg"}, 32'(negative), 32'(eo[15]));
    endtask

    initial begin
        int lat;
        int pulses;
        checks = 0;
        failures = 0;
        start = 0; dir = 0; arith = 0; rotate = 0; amount = 0; in_data = 0;

        //            d     a     r     amt    din       out       cy
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 4'd4,  16'h8421, 16'h4210, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 4'd3,  16'h8010, 16'hF002, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 4'd15, 16'h0001, 16'h0002, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 4'd1,  16'h8000, 16'h0001, 1'b1};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 4'd1,  16'h0001, 16'h0000, 1'b1};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 4'd0,  16'h1234, 16'h1234, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 4'd15, 16'h0003, 16'h8000, 1'b1};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 4'd15, 16'h8000, 16'h0001, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 4'd15, 16'h8000, 16'hFFFF, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 4'd4,  16'h7FF0, 16'h07FF, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 1'b1, 4'd4,  16'h8001, 16'h1800, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 4'd1,  16'h8001, 16'h0002, 1'b1};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 4'd2,  16'h0006, 16'h0001, 1'b1};

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_out", 32'(out_data), 32'd0);
        chk("rst_zero", 32'(zero), 32'd1);
        chk("rst_carry", 32'(carry_out), 32'd0);
        chk("rst_neg", 32'(negative), 32'd0);

        for (int i = 0; i < 13; i++) begin
            start_op(vecs[i].d, vecs[i].a, vecs[i].r, vecs[i].amt, vecs[i].din);
            chk($sformatf("v%0d_busy_k", i), 32'(busy), 32'(exp_busy(vecs[i].amt)));
            wait_done(lat);
            chk($sformatf("v%0d_lat", i), 32'(lat), 32'(exp_lat(vecs[i].amt)));
            chk($sformatf("v%0d_busy_done", i), 32'(busy), 32'd0);
            chk_result($sformatf("v%0d", i), vecs[i].exp_out, vecs[i].exp_cy);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_done_pulse", i), 32'(done), 32'd0);
        end

        // Back-to-back: new start presented during the DONE cycle.
        start_op(1'b0, 1'b0, 1'b0, 4'd4, 16'h8421);
        wait_done(lat);
        dir = 1'b0; arith = 1'b0; rotate = 1'b0; amount = 4'd0; in_data = 16'h1234; start = 1'b1;
        chk("b2b_old_out", 32'(out_data), 32'h4210);
        @(posedge clk);
        #1;
        in_data = 16'hABCD;
        chk("b2b_busy", 32'(busy), 32'(exp_busy(4'd0)));
        chk("b2b_done_low", 32'(done), 32'd0);
        wait_done(lat);
        chk("b2b_lat", 32'(lat), 32'(exp_lat(4'd0)));
        chk_result("b2b", 16'h1234, 1'b0);
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(lat);
        chk("b2b2_lat", 32'(lat), 32'(exp_lat(4'd0)));
        chk_result("b2b2", 16'hABCD, 1'b0);

        // Start pulsed mid-operation must be neither taken nor queued.
        start_op(1'b1, 1'b0, 1'b0, 4'd1, 16'h0001);
        lat = 0;
        while (!done && lat < 40) begin
            start = (lat == 1);
            in_data = 16'hFFFF;
            amount = 4'd0;
            @(posedge clk);
            #1;
            lat++;
        end
        start = 1'b0;
        chk("mid_lat", 32'(lat), 32'd4);
        chk_result("mid", 16'h0000, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        chk("mid_no_queue_busy", 32'(busy), 32'd0);
        chk("mid_no_queue_done", 32'(done), 32'd0);

        // Establish a nonzero result, then reset at edge k+2 with start also high.
        start_op(1'b0, 1'b0, 1'b0, 4'd1, 16'h0001);
        wait_done(lat);
        chk_result("pre_rst", 16'h0002, 1'b0);
        start_op(1'b0, 1'b0, 1'b0, 4'd4, 16'h8421);
        @(posedge clk);
        #1;
        rst = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        start = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_out", 32'(out_data), 32'd0);
        chk("abort_zero", 32'(zero), 32'd1);
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            if (done || busy) pulses++;
        end
        chk("abort_no_done", 32'(pulses), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
